// File: rtl/mem_stage_ctrl.sv
// Memory stage of the RV32 pipeline: owns the data RAM, formats loads, stalls for LATENCY cycles.
// Optional macro MISALIGN_TRAP_EN: suppress misaligned H/W accesses instead of force-aligning them.
module mem_stage_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_m,
    input  logic [ADDR_WIDTH-1:0] alu_result_m,
    input  logic [DATA_WIDTH-1:0] write_data_m,
    input  logic                  mem_write_m,
    input  logic                  mem_read_m,
    input  logic [2:0]            funct3_m,
    input  logic [4:0]            rd_m,
    input  logic                  reg_write_m,
    input  logic [1:0]            result_src_m,
    input  logic [DATA_WIDTH-1:0] pc_plus4_m,
    output logic                  stall_m,
    output logic                  valid_w,
    output logic [DATA_WIDTH-1:0] read_data_w,
    output logic [DATA_WIDTH-1:0] alu_result_w,
    output logic [DATA_WIDTH-1:0] pc_plus4_w,
    output logic [4:0]            rd_w,
    output logic                  reg_write_w,
    output logic [1:0]            result_src_w,
    output logic                  misaligned_w
);

    localparam int          IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [2:0]  LAT3  = 3'(LATENCY);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t                  state_q, state_d;
    logic [2:0]              cnt_q, cnt_d;
    logic                    valid_q, valid_d;
    logic [DATA_WIDTH-1:0]   read_data_q, read_data_d;
    logic [DATA_WIDTH-1:0]   alu_result_q, alu_result_d;
    logic [DATA_WIDTH-1:0]   pc_plus4_q, pc_plus4_d;
    logic [4:0]              rd_q, rd_d;
    logic                    reg_write_q, reg_write_d;
    logic [1:0]              result_src_q, result_src_d;
    logic                    misaligned_q, misaligned_d;

    logic [DATA_WIDTH-1:0]   ram [DEPTH_WORDS];

    logic                    is_mem, misaligned, acc, is_load;
    logic                    size_b, size_h, size_w;
    logic [1:0]              lane_ofs;
    logic [IDX_W-1:0]        word_idx;
    logic                    stall, complete, we;
    logic [3:0]              be;
    logic [DATA_WIDTH-1:0]   wdata, rword, rshift, load_fmt;

    assign is_mem   = valid_m & (mem_read_m | mem_write_m);
    assign size_b   = (funct3_m[1:0] == 2'b00);
    assign size_h   = (funct3_m[1:0] == 2'b01);
    assign size_w   = ~size_b & ~size_h;
    assign word_idx = alu_result_m[IDX_W+1:2];

`ifdef MISALIGN_TRAP_EN
    assign misaligned = is_mem & ((size_h & alu_result_m[0]) | (size_w & (|alu_result_m[1:0])));
    assign lane_ofs   = alu_result_m[1:0];
`else
    // Without the trap, H and W accesses are silently forced to natural alignment.
    assign misaligned = 1'b0;
    assign lane_ofs   = size_w ? 2'b00 : (size_h ? {alu_result_m[1], 1'b0} : alu_result_m[1:0]);
`endif

    assign acc     = is_mem & ~misaligned;
    assign is_load = mem_read_m & ~mem_write_m;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall    = 1'b0;
        complete = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (acc) begin
                    if (LATENCY == 0) begin
                        complete = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        cnt_d   = LAT3;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 3'd1) begin
                    complete = 1'b1;
                    cnt_d    = 3'd0;
                    state_d  = ST_IDLE;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // Gate with reset so an access held at the inputs cannot stall or write while reset is low.
    assign stall_m = stall & rst;
    assign we      = complete & mem_write_m & rst;

    always_comb begin
        be    = 4'b1111;
        wdata = write_data_m;
        if (size_b) begin
            be    = 4'b0001 << lane_ofs;
            wdata = {4{write_data_m[7:0]}};
        end else if (size_h) begin
            be    = 4'b0011 << lane_ofs;
            wdata = {2{write_data_m[15:0]}};
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) ram[word_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rword  = ram[word_idx];
    assign rshift = rword >> {lane_ofs, 3'b000};

    always_comb begin
        load_fmt = rword;
        if (size_b)
            load_fmt = {{(DATA_WIDTH-8){~funct3_m[2] & rshift[7]}}, rshift[7:0]};
        else if (size_h)
            load_fmt = {{(DATA_WIDTH-16){~funct3_m[2] & rshift[15]}}, rshift[15:0]};
    end

    always_comb begin
        valid_d      = valid_q;
        read_data_d  = read_data_q;
        alu_result_d = alu_result_q;
        pc_plus4_d   = pc_plus4_q;
        rd_d         = rd_q;
        reg_write_d  = reg_write_q;
        result_src_d = result_src_q;
        misaligned_d = misaligned_q;
        if (stall) begin
            valid_d      = 1'b0;
            reg_write_d  = 1'b0;
            misaligned_d = 1'b0;
        end else begin
            valid_d      = valid_m;
            reg_write_d  = reg_write_m & valid_m & ~misaligned;
            misaligned_d = misaligned;
            alu_result_d = DATA_WIDTH'(alu_result_m);
            pc_plus4_d   = pc_plus4_m;
            rd_d         = rd_m;
            result_src_d = result_src_m;
            if (complete & is_load) read_data_d = load_fmt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 3'd0;
            valid_q      <= 1'b0;
            read_data_q  <= '0;
            alu_result_q <= '0;
            pc_plus4_q   <= '0;
            rd_q         <= '0;
            reg_write_q  <= 1'b0;
            result_src_q <= '0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            valid_q      <= valid_d;
            read_data_q  <= read_data_d;
            alu_result_q <= alu_result_d;
            pc_plus4_q   <= pc_plus4_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
            result_src_q <= result_src_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign valid_w      = valid_q;
    assign read_data_w  = read_data_q;
    assign alu_result_w = alu_result_q;
    assign pc_plus4_w   = pc_plus4_q;
    assign rd_w         = rd_q;
    assign reg_write_w  = reg_write_q;
    assign result_src_w = result_src_q;
    assign misaligned_w = misaligned_q;

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
Parametrised memory stage for the pipelined RV32 core. Sits between the execute/memory pipeline register and writeback, and owns the data RAM. Supports byte/halfword/word loads and stores with sign/zero extension, a configurable read/write latency that stalls upstream, and a registered MEM/WB output. Non-memory instructions pass through to writeback in one cycle.

Parameters:
DATA_WIDTH, 32, datapath width; fixed at 32 for RV32 (byte lanes = 4)
ADDR_WIDTH, 32, width of alu_result_m used as byte address
DEPTH_WORDS, 1024, RAM depth in words; power of 2
LATENCY, 0, extra wait cycles per memory access (0..7)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
valid_m  in  1  M-stage instruction valid
alu_result_m  in  ADDR_WIDTH  byte address, or ALU result for pass-through
write_data_m  in  DATA_WIDTH  store data, unshifted, from rs2
mem_write_m  in  1  store
mem_read_m  in  1  load
funct3_m  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
rd_m  in  5  destination register
reg_write_m  in  1  writeback enable
result_src_m  in  2  writeback mux select, passed through
pc_plus4_m  in  DATA_WIDTH  passed through
stall_m  out  1  hold M stage and all earlier stages
valid_w  out  1  W-stage valid
read_data_w  out  DATA_WIDTH  formatted load data
alu_result_w  out  DATA_WIDTH  passed through
pc_plus4_w  out  DATA_WIDTH  passed through
rd_w  out  5  passed through
reg_write_w  out  1  gated writeback enable
result_src_w  out  2  passed through
misaligned_w  out  1  access in this W slot was misaligned and suppressed

Behaviour:
- Reset (rst=0, async): all *_w outputs 0, FSM IDLE, wait counter 0, stall_m 0. RAM contents are not reset.
- Access condition: acc = valid_m & (mem_read_m | mem_write_m) & ~misaligned. Both read and write set: treat as a store.
- Word index = alu_result_m[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- FSM states:
  - IDLE: if acc and LATENCY>0, load counter=LATENCY, assert stall_m combinationally, go to WAIT. If acc and LATENCY=0, complete at this edge.
  - WAIT: stall_m=1. Counter decrements each cycle. When counter=1, deassert stall_m, complete at this edge, and return to IDLE.
  - A LATENCY=N access therefore holds stall_m high for exactly N cycles. Completion occurs at cycle N+1 after acceptance.
- Upstream holds all *_m inputs stable while stall_m=1. The block samples them only at the completion edge.
- While stall_m=1, the W register loads a bubble: valid_w=0, reg_write_w=0, misaligned_w=0. Other W fields hold their values.
- Completion edge (and every non-stalled edge): the W register captures the pass-through fields. valid_w=valid_m and reg_write_w=reg_write_m&valid_m&~misaligned.
- Store completion: write byte lanes once, at the completion edge only.
  - SB: write data[7:0] to lane addr[1:0].
  - SH: write data[15:0] to lanes {addr[1],0}+1:0.
  - SW: write all lanes.
- Load completion: select the byte/halfword by addr[1:0] and extend per funct3: B/H sign-extend, BU/HU zero-extend, W unchanged. Result goes to read_data_w.
- Load after store to the same word in consecutive instructions returns the new data (read sees completed write).
- Invalid funct3 on an access (011, 110, 111): treat as W.
- Non-memory instruction, or valid_m=0: no stall, no RAM activity; read_data_w holds its previous value.
- Reset asserted mid-WAIT: abort the access (no RAM write), return to IDLE, stall_m=0 immediately.

Optional Feature:
MISALIGN_TRAP_EN.
- Defined: H with addr[0]=1, or W with addr[1:0]!=0, is misaligned. No RAM access and no stall occur. The W slot gets misaligned_w=1 and reg_write_w=0.
- Undefined: misaligned_w is tied to 0. Low address bits are forced to the natural alignment (H clears bit 0, W clears bits 1:0), and the access proceeds normally.

Test Plan:
1. LATENCY=0: SW 0xDEADBEEF @0x10, then LW @0x10 → read_data_w=0xDEADBEEF one cycle later, stall_m never high.
2. SB 0x80 @0x13 over the word 0xDEADBEEF @0x10 → word=0x80ADBEEF. LB @0x13 → 0xFFFFFF80. LBU @0x13 → 0x00000080. LH @0x12 → 0xFFFF80AD. LHU @0x12 → 0x000080AD.
3. LATENCY=3, LW @0x20 → stall_m high exactly 3 cycles; W slot shows bubbles (valid_w=0) for those cycles, then data valid with reg_write_w=1. A following ADD passes with no stall.
4. LATENCY=2, SW @0x40, rst pulled low in the 2nd stall cycle → stall_m=0 immediately, all *_w=0, and a later LW @0x40 returns the prior contents.
5. MISALIGN_TRAP_EN defined: LW @0x22 → misaligned_w=1, reg_write_w=0, no stall. Same test undefined → LW reads word @0x20.
6. Address wrap with DEPTH_WORDS=1024: SW 0x12345678 @0x1004 → LW @0x0004 returns 0x12345678.
